// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields and a signed immediate into a
// 32-bit word, assigns it an instruction-memory word address, and streams it out
// through a two-stage valid/ready pipeline. Illegal requests become NOP with out_err_o.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        in_opcode_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_word_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_err_o,
  output logic [7:0]        err_count_o,
  output logic              wrapped_o
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MaxAddr  = '1;
  localparam logic [31:0]       Nop      = 32'h0000_0013;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // Stage 1 state
  logic        s1_valid_q;
  logic [6:0]  s1_op_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [31:0] s1_imm_q;
  logic        s1_legal_q;

  // Stage 2 state
  logic              s2_valid_q;
  logic [31:0]       s2_word_q;
  logic              s2_err_q;
  logic [ADDR_W-1:0] s2_addr_q;

  logic [ADDR_W-1:0] alloc_q, alloc_d, alloc_base;
  logic [7:0]        err_count_q, err_count_d;
  logic              wrapped_q, wrapped_d;

  logic        s1_adv, s2_adv, xfer, out_hs;
  logic        in_legal;
  logic        imm12_ok, imm13_ok, imm21_ok;
  logic [31:0] enc_word;

  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;
  assign xfer       = s1_valid_q && s2_adv;
  assign out_hs     = s2_valid_q && out_ready_i;

  // Immediate range checks: the bits above the field's sign bit must all match it
  assign imm12_ok = (in_imm_i[31:11] == '0) || (in_imm_i[31:11] == '1);
  assign imm13_ok = (in_imm_i[31:12] == '0) || (in_imm_i[31:12] == '1);
  assign imm21_ok = (in_imm_i[31:20] == '0) || (in_imm_i[31:20] == '1);

  // Legality of the incoming request, decided per opcode
  always_comb begin
    in_legal = 1'b0;
    case (in_opcode_i)
      OpLui, OpAuipc:         in_legal = (in_imm_i[11:0] == 12'h000);
      OpJal:                  in_legal = !in_imm_i[0] && imm21_ok;
      OpJalr, OpLoad, OpImm:  in_legal = imm12_ok;
      OpBranch:               in_legal = !in_imm_i[0] && imm13_ok;
      OpStore:                in_legal = imm12_ok;
      OpReg:                  in_legal = 1'b1;
      default:                in_legal = 1'b0;
    endcase
  end

  // Stage 1: capture request fields and legality when the stage can advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_imm_q   <= '0;
      s1_legal_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_op_q    <= in_opcode_i;
        s1_rd_q    <= in_rd_i;
        s1_rs1_q   <= in_rs1_i;
        s1_rs2_q   <= in_rs2_i;
        s1_f3_q    <= in_funct3_i;
        s1_f7_q    <= in_funct7_i;
        s1_imm_q   <= in_imm_i;
        s1_legal_q <= in_legal;
      end
    end
  end

  // Pack the stage-1 fields into an instruction word; illegal requests become NOP
  always_comb begin
    enc_word = Nop;
    case (s1_op_q)
      OpLui, OpAuipc: enc_word = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      OpJal: enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_rd_q, s1_op_q};
      OpJalr, OpLoad, OpImm: enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OpBranch: enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      OpStore: enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                           s1_op_q};
      OpReg: enc_word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      default: enc_word = Nop;
    endcase
    if (!s1_legal_q) enc_word = Nop;
  end

  // Address allocation: a restart coinciding with a transfer hands it BASE_ADDR
  always_comb begin
    alloc_base = restart_i ? BaseAddr : alloc_q;
    alloc_d    = xfer ? alloc_base + ADDR_W'(1) : alloc_base;
  end

  // Stage 2: register packed word, error flag and allocated address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_addr_q  <= BaseAddr;
      alloc_q    <= BaseAddr;
    end else begin
      alloc_q <= alloc_d;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_word_q <= enc_word;
          s2_err_q  <= !s1_legal_q;
          s2_addr_q <= alloc_base;
        end
      end
    end
  end

  // Handoff statistics; restart wins over a coincident handshake
  always_comb begin
    err_count_d = err_count_q;
    wrapped_d   = wrapped_q;
    if (restart_i) begin
      err_count_d = '0;
      wrapped_d   = 1'b0;
    end else begin
      if (out_hs && s2_err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      if (out_hs && (s2_addr_q == MaxAddr)) wrapped_d = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_word_o  = s2_word_q;
  assign out_err_o   = s2_err_q;
  assign out_addr_o  = s2_addr_q;
  assign err_count_o = err_count_q;
  assign wrapped_o   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard queue. A second instance with a
// 2-bit address counter shares the stimulus to exercise address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [6:0]  op = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, out_valid, out_err, wrapped;
  logic [31:0] out_word;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  logic        in_ready_w, out_valid_w, out_err_w, wrapped_w;
  logic [31:0] out_word_w;
  logic [1:0]  out_addr_w;
  logic [7:0]  err_count_w;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .restart_i(restart), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_opcode_i(op), .in_rd_i(rd), .in_rs1_i(rs1), .in_rs2_i(rs2),
    .in_funct3_i(f3), .in_funct7_i(f7), .in_imm_i(imm), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_word_o(out_word), .out_addr_o(out_addr),
    .out_err_o(out_err), .err_count_o(err_count), .wrapped_o(wrapped)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .restart_i(restart), .in_valid_i(in_valid),
    .in_ready_o(in_ready_w), .in_opcode_i(op), .in_rd_i(rd), .in_rs1_i(rs1), .in_rs2_i(rs2),
    .in_funct3_i(f3), .in_funct7_i(f7), .in_imm_i(imm), .out_valid_o(out_valid_w),
    .out_ready_i(out_ready), .out_word_o(out_word_w), .out_addr_o(out_addr_w),
    .out_err_o(out_err_w), .err_count_o(err_count_w), .wrapped_o(wrapped_w)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [9:0]  a;
    logic        e;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         nchk = 0, npass = 0, npop = 0, hs_w = 0, err_model = 0;
  logic [9:0] exp_addr = '0;
  logic       acc = 1'b0, last_ov = 1'b0, last_ir = 1'b0, wrap_on = 1'b0;
  logic       held = 1'b0, he = 1'b0;
  logic [31:0] hw = '0;
  logic [9:0]  ha = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Independent reference encoder using integer range checks
  function automatic exp_t model(input logic [6:0] o, input logic [4:0] d, s1, s2,
                                 input logic [2:0] f, input logic [6:0] f7v,
                                 input logic [31:0] im);
    exp_t r;
    int   si;
    si  = $signed(im);
    r.a = '0;
    r.e = 1'b0;
    r.w = 32'h13;
    case (o)
      7'h37, 7'h17: begin
        r.e = (im[11:0] != 12'h0);
        r.w = {im[31:12], d, o};
      end
      7'h6f: begin
        r.e = im[0] || si < -1048576 || si > 1048575;
        r.w = {im[20], im[10:1], im[11], im[19:12], d, o};
      end
      7'h67, 7'h03, 7'h13: begin
        r.e = si < -2048 || si > 2047;
        r.w = {im[11:0], s1, f, d, o};
      end
      7'h63: begin
        r.e = im[0] || si < -4096 || si > 4095;
        r.w = {im[12], im[10:5], s2, s1, f, im[4:1], im[11], o};
      end
      7'h23: begin
        r.e = si < -2048 || si > 2047;
        r.w = {im[11:5], s2, s1, f, im[4:0], o};
      end
      7'h33: r.w = {f7v, s2, s1, f, d, o};
      default: r.e = 1'b1;
    endcase
    if (r.e) r.w = 32'h13;
    return r;
  endfunction

  // One clock: sample at negedge, score handshakes, return just after posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_ov = out_valid;
    last_ir = in_ready;
    if (wrap_on) chk("wrapped_w", {31'b0, wrapped_w}, (hs_w >= 4) ? 32'd1 : 32'd0);
    if (held && !rst) begin
      chk("hold_word", out_word, hw);
      chk("hold_addr", {22'b0, out_addr}, {22'b0, ha});
      chk("hold_err", {31'b0, out_err}, {31'b0, he});
    end
    held = out_valid && !out_ready && !rst;
    hw = out_word;
    ha = out_addr;
    he = out_err;
    if (out_valid && out_ready && !rst) begin
      nchk++;
      assert (sb.size() != 0) npass++;
      else $error("FAIL spurious_out: observed word %h, expected no output", out_word);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word", out_word, e.w);
        chk("addr", {22'b0, out_addr}, {22'b0, e.a});
        chk("err", {31'b0, out_err}, {31'b0, e.e});
        chk("word_w", out_word_w, e.w);
        chk("addr_w", {30'b0, out_addr_w}, {30'b0, e.a[1:0]});
        chk("err_w", {31'b0, out_err_w}, {31'b0, e.e});
        if (e.e && err_model < 255) err_model++;
        if (wrap_on) hs_w++;
        npop++;
      end
    end
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      e   = cur;
      e.a = exp_addr;
      sb.push_back(e);
      exp_addr = exp_addr + 10'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] o, input logic [4:0] d, s1, s2,
                            input logic [2:0] f, input logic [6:0] f7v,
                            input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; f3 = f; f7 = f7v; imm = im;
    in_valid = 1'b1;
    cur = model(o, d, s1, s2, f, f7v, im);
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) return;
    end
    nchk++;
    $error("FAIL accept_timeout: observed no accept in 50 cycles, expected accept");
  endtask

  // Send with an explicitly stated expected word and error flag
  task automatic send(input logic [6:0] o, input logic [4:0] d, s1, s2,
                      input logic [2:0] f, input logic [6:0] f7v, input logic [31:0] im,
                      input logic [31:0] w, input logic e);
    set_fields(o, d, s1, s2, f, f7v, im);
    cur.w = w;
    cur.e = e;
    wait_accept();
  endtask

  task automatic sendm(input logic [6:0] o, input logic [4:0] d, s1, s2,
                       input logic [2:0] f, input logic [6:0] f7v, input logic [31:0] im);
    set_fields(o, d, s1, s2, f, f7v, im);
    wait_accept();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) return;
      cycle();
    end
    nchk++;
    $error("FAIL drain_timeout: observed %0d words outstanding, expected 0", sb.size());
  endtask

  task automatic do_restart();
    in_valid = 1'b0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    exp_addr = '0;
    err_model = 0;
  endtask

  initial begin
    int p, idx;
    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_out_addr", {22'b0, out_addr}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    chk("rst_wrapped", {31'b0, wrapped}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // ADDI x1,x0,5 with two-cycle latency
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    in_valid = 1'b0;
    cycle();
    chk("lat_cycle1", {31'b0, last_ov}, 32'd0);
    cycle();
    chk("lat_cycle2", {31'b0, last_ov}, 32'd1);
    drain();

    // Back-to-back mix at addresses 0..3
    do_restart();
    p = npop;
    send(7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_5137, 1'b0);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE20_8EE3, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    chk("b2b_pops_mid", npop, p + 2);
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("b2b_pops_end", npop, p + 4);

    // Illegal requests give NOP and still consume addresses
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h13, 1'b1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h13, 1'b1);
    send(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 1'b1);
    drain();
    chk("err_count_3", {24'b0, err_count}, 32'd3);

    // Boundary immediates through the reference model
    sendm(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, -32'sd2048);
    sendm(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd7, 7'd0, 32'd2047);
    sendm(7'b0000011, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, -32'sd2049);
    sendm(7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E001);
    sendm(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE);
    sendm(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    sendm(7'b1100011, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, -32'sd4096);
    sendm(7'b1100011, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, 32'd4096);
    sendm(7'b0100011, 5'd0, 5'd10, 5'd11, 3'd0, 7'd0, -32'sd1);
    sendm(7'b0110011, 5'd12, 5'd13, 5'd14, 3'd5, 7'b0100000, 32'hFFFF_FFFF);
    sendm(7'b1100111, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd12);
    drain();
    chk("err_count_model", {24'b0, err_count}, err_model);

    // Backpressure: out_ready low for iterations 1..5 while five requests are offered
    idx = 0;
    for (int k = 0; k < 40; k++) begin
      if (idx < 5) set_fields(7'b0010011, 5'(idx + 3), 5'd1, 5'd0, 3'd0, 7'd0, 32'(idx * 7));
      else in_valid = 1'b0;
      out_ready = !(k >= 1 && k <= 5);
      cycle();
      if (acc) idx++;
      if (k == 4) begin
        chk("bp_in_ready_low", {31'b0, last_ir}, 32'd0);
        chk("bp_held_words", sb.size(), 32'd2);
      end
      if (idx == 5 && sb.size() == 0) break;
    end
    out_ready = 1'b1;
    chk("bp_all_accepted", idx, 32'd5);
    drain();

    // Address wrap on the 2-bit instance
    do_restart();
    chk("restart_err_count", {24'b0, err_count}, 32'd0);
    hs_w = 0;
    wrap_on = 1'b1;
    for (int k = 0; k < 5; k++) sendm(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    drain();
    cycle();
    chk("wrap_set", {31'b0, wrapped_w}, 32'd1);
    wrap_on = 1'b0;
    do_restart();
    chk("wrap_cleared", {31'b0, wrapped_w}, 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    sendm(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    sendm(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    sb.delete();
    exp_addr = '0;
    err_model = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("mid_rst_out_valid", {31'b0, last_ov}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, last_ir}, 32'd1);
    chk("mid_rst_out_addr", {22'b0, out_addr}, 32'd0);
    sendm(7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    drain();

    chk("no_wrap_10b", {31'b0, wrapped}, 32'd0);
    chk("err_count_match_w", {24'b0, err_count_w}, {24'b0, err_count});

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
